mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the CPU load/store path. Accepts one word-granular
//  request at a time over a valid/ready channel, applies byte-masked writes to an
//  internal word array, and returns read data or an error over a response channel
//  after a fixed, configurable latency. Serves as the multi-cycle replacement for
//  the DPI-C pmem backing and the ad-hoc stack array behind the memory interface.
// PARAMETERS
//  ADDR_BASE    32'h80000000  byte address of word 0 of the array
//  DEPTH_WORDS  1024          number of 32-bit words (power of 2, >=2)
//  LATENCY      2             cycles from request accept to rsp_valid (>=1)
// PORTS
//  clk         in   1   clock, all logic on rising edge
//  rst         in   1   synchronous reset, active-low (rst==0 resets)
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_addr    in   32  byte address; bits [1:0] ignored for indexing
//  req_wen     in   1   1 = write, 0 = read
//  req_wdata   in   32  write data, lane-aligned (byte k in bits [8k+7:8k])
//  req_wmask   in   4   byte enables for writes; ignored for reads
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   initiator accepts response
//  rsp_rdata   out  32  full read word (0 for writes and errors)
//  rsp_err     out  1   address outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS)
// BEHAVIOUR
//  - Reset (rst==0 at edge): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    latency counter=0. Array contents are not reset (zero at sim start only).
//  - FSM IDLE -> WAIT -> RESP -> IDLE. req_ready = (state==IDLE), combinational.
//  - IDLE: on req_valid&&req_ready latch addr/wen/wdata/wmask, load counter with
//    LATENCY-1; if LATENCY==1 go straight to RESP, else go to WAIT.
//  - WAIT: decrement counter each cycle; at counter==1 go to RESP next edge.
//  - Entry edge into RESP (exactly LATENCY edges after the accept edge):
//    in-range read -> rsp_rdata=mem[idx]; in-range write -> bytes with wmask=1
//    updated, rsp_rdata=0; out-of-range -> rsp_err=1, rsp_rdata=0, no write.
//    idx = (addr-ADDR_BASE)>>2, truncated to log2(DEPTH_WORDS) bits.
//  - RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready;
//    on that edge rsp_valid=0, rsp_err=0, return to IDLE. No request accepted in
//    the handshake cycle; max throughput one transaction per LATENCY+1 cycles.
//  - Write with wmask==0: legal, array unchanged, normal response err=0.
//  - Address compare done in 33-bit unsigned arithmetic; top-of-range wrap at
//    32'hFFFFFFFF cannot alias into the array.
//  - Reset mid-WAIT/RESP: transaction dropped, no response; a write not yet
//    committed (still in WAIT) never reaches the array.
//  - Inputs other than req_valid are don't-care outside the accept cycle.
// TESTING (LATENCY=2, DEPTH_WORDS=1024 unless stated)
//  1. Write 0x80000010 data DEADBEEF mask 1111, then read 0x80000010 -> write
//     rsp_valid 2 cycles after accept err=0; read rsp_rdata=DEADBEEF.
//  2. Then write 0x80000011 data 0000AB00 mask 0010, read -> rsp_rdata=DEADABEF.
//  3. Read 0x80001000 and write 0x7FFFFFFC data 12345678 -> both rsp_err=1,
//     rsp_rdata=0; read 0x80000000 still returns prior value.
//  4. Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid/rdata/err stable,
//     req_ready=0 throughout; second request accepted only after handshake.
//  5. Assert rst=0 one cycle after accepting write to 0x80000020 -> rsp_valid=0,
//     req_ready=1 after release; read 0x80000020 returns old value.
//  6. LATENCY=1, rsp_ready tied 1, req_valid held 1 -> accepts every 2nd cycle,
//     each rsp_valid pulse exactly 1 cycle after its accept.

Source files
------------

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request in, fixed-latency response out,
// byte-masked writes into an internal word array with address range checking.
module mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam int          CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] LIMIT = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [31:0]        lat_addr, lat_wdata;
  logic               lat_wen;
  logic [3:0]         lat_wmask;
  logic [31:0]        mem [DEPTH_WORDS];

  logic [31:0]        eff_addr, eff_wdata;
  logic               eff_wen;
  logic [3:0]         eff_wmask;
  logic [32:0]        offset;
  logic [IDX_W-1:0]   idx;
  logic               in_range, accept, enter_resp, handshake;
  logic               unused_offset_bits;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign handshake = rsp_valid && rsp_ready;

  // With LATENCY==1 the commit happens on the accept edge, so the live request is used then.
  always_comb begin
    eff_addr  = lat_addr;
    eff_wen   = lat_wen;
    eff_wdata = lat_wdata;
    eff_wmask = lat_wmask;
    if (state == IDLE) begin
      eff_addr  = req_addr;
      eff_wen   = req_wen;
      eff_wdata = req_wdata;
      eff_wmask = req_wmask;
    end
    offset   = {1'b0, eff_addr} - {1'b0, ADDR_BASE};
    idx      = offset[IDX_W+1:2];
    in_range = ({1'b0, eff_addr} >= {1'b0, ADDR_BASE}) && ({1'b0, eff_addr} < LIMIT);
  end

  assign unused_offset_bits = ^{offset[32:IDX_W+2], offset[1:0]};

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    enter_resp = (state != RESP) && (state_next == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (enter_resp) begin
        rsp_err   <= !in_range;
        rsp_rdata <= (in_range && !eff_wen) ? mem[idx] : 32'h0;
      end else if (handshake) begin
        rsp_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr  <= req_addr;
      lat_wen   <= req_wen;
      lat_wdata <= req_wdata;
      lat_wmask <= req_wmask;
    end
  end

  // Writes land only when the response is produced, so a reset during WAIT drops them.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && in_range && eff_wen) begin
      for (int k = 0; k < 4; k++) begin
        if (eff_wmask[k]) mem[idx][8*k +: 8] <= eff_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an associative-array memory model;
// a second instance with LATENCY=1 checks back-to-back throughput.
module tb_mem_responder;

  localparam logic [31:0] ADDR_BASE = 32'h8000_0000;
  localparam int          DEPTH     = 1024;
  localparam longint      BASE_L    = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wmask;

  logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_err;
  logic [31:0] r1_req_addr, r1_rsp_rdata;

  int checks = 0;
  int passes = 0;
  logic [31:0] model_mem [int];

  mem_responder #(.ADDR_BASE(ADDR_BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.ADDR_BASE(ADDR_BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_addr(r1_req_addr),
    .req_wen(1'b0), .req_wdata(32'h0), .req_wmask(4'h0),
    .rsp_valid(r1_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(r1_rsp_rdata), .rsp_err(r1_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Reference memory: byte address -> word index by plain arithmetic, range check on 64-bit values.
  function automatic void model(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                                input logic [3:0] wmask, output logic err, output logic [31:0] rdata,
                                output bit known);
    longint a;
    int idx;
    logic [31:0] word;
    a = {32'h0, addr};
    err = 1'b0; rdata = 32'h0; known = 1'b1;
    if (a < BASE_L || a >= BASE_L + 4 * DEPTH) begin
      err = 1'b1;
    end else begin
      idx = int'((a - BASE_L) / 4);
      if (wen) begin
        word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        for (int k = 0; k < 4; k++) if (wmask[k]) word[8*k +: 8] = wdata[8*k +: 8];
        model_mem[idx] = word;
      end else if (model_mem.exists(idx)) begin
        rdata = model_mem[idx];
      end else begin
        known = 1'b0;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                               input logic [3:0] wmask, input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata, held_rdata;
    logic        held_err;
    bit          known;
    int          waited;
    model(addr, wen, wdata, wmask, exp_err, exp_rdata, known);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_wdata = wdata; req_wmask = wmask;
    waited = 0;
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    checkOutput("req_ready_at_accept", req_ready, 1);
    @(negedge clk);
    req_valid = (hold > 0); req_addr = ADDR_BASE; req_wen = 1'b1; req_wdata = 32'h0; req_wmask = 4'hF;
    waited = 1;
    while (!rsp_valid && waited < 20) begin @(negedge clk); waited++; end
    checkOutput("latency", waited, 2);
    checkOutput("rsp_err", rsp_err, exp_err);
    if (known) checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_rdata", rsp_rdata, held_rdata);
      checkOutput("hold_rsp_err", rsp_err, held_err);
      checkOutput("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("post_rsp_valid", rsp_valid, 0);
    checkOutput("post_req_ready", req_ready, 1);
  endtask

  function automatic logic [31:0] pickAddr();
    case ($urandom_range(0, 9))
      0:       return ADDR_BASE - 32'd4 + 32'($urandom_range(0, 3));
      1:       return ADDR_BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 3));
      2:       return 32'hFFFF_FFFC;
      3:       return ADDR_BASE + 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
      default: return ADDR_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic        exp_err1;
    logic [31:0] old_word;
    rst = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wen = 1'b0; req_wdata = 32'h0;
    req_wmask = 4'h0; rsp_ready = 1'b0; r1_req_valid = 1'b0; r1_req_addr = 32'h0;
    exp_err1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);

    for (int w = 0; w < 16; w++) applyStimulus(ADDR_BASE + 32'(4 * w), 1'b1, $urandom, 4'hF, 0);
    applyStimulus(ADDR_BASE + 32'(4 * (DEPTH - 1)), 1'b1, $urandom, 4'hF, 0);

    applyStimulus(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
    applyStimulus(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0);
    applyStimulus(32'h8000_0011, 1'b1, 32'h0000_AB00, 4'h2, 0);
    applyStimulus(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0);
    checkOutput("merged_word", rsp_rdata, 32'hDEAD_ABEF);
    applyStimulus(32'h8000_1000, 1'b0, 32'h0, 4'h0, 0);
    applyStimulus(32'h7FFF_FFFC, 1'b1, 32'h1234_5678, 4'hF, 0);
    applyStimulus(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0);
    applyStimulus(32'h8000_0014, 1'b1, 32'hFFFF_FFFF, 4'h0, 0);
    applyStimulus(32'h8000_0014, 1'b0, 32'h0, 4'h0, 5);

    old_word = model_mem[8];
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0020; req_wen = 1'b1; req_wdata = ~old_word; req_wmask = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_rsp_valid", rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_rsp_valid_after", rsp_valid, 0);
    checkOutput("midreset_req_ready", req_ready, 1);
    applyStimulus(32'h8000_0020, 1'b0, 32'h0, 4'h0, 0);
    checkOutput("dropped_write", rsp_rdata, old_word);

    for (int t = 0; t < 60; t++)
      applyStimulus(pickAddr(), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3));

    @(negedge clk);
    r1_req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("lat1_req_ready", r1_req_ready, 32'(i % 2 == 0));
      checkOutput("lat1_rsp_valid", r1_rsp_valid, 32'(i % 2 == 1));
      if (i % 2 == 1) begin
        checkOutput("lat1_rsp_err", r1_rsp_err, exp_err1);
        if (exp_err1) checkOutput("lat1_err_rdata", r1_rsp_rdata, 0);
      end else begin
        exp_err1 = 1'($urandom_range(0, 1));
        r1_req_addr = exp_err1 ? ADDR_BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7))
                               : ADDR_BASE + 32'(4 * $urandom_range(0, 15));
      end
      @(negedge clk);
    end
    r1_req_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
